vga_monitor: RTL and testbench
==============================

Name: vga_monitor

Overview:
- Receive-side model of the VGA output port: samples VGA_CLK/HS/VS/BLANK_N/RGB exactly as they leave video_driver.
- Recovers the pixel (x, y) coordinates, re-emits a pixel stream, measures line and frame geometry, and produces a per-frame RGB565 checksum.
- Sits beside the top level in simulation and on-board self-test, closing the loop on video_driver + animator output.

Parameters:
WIDTH, 640, expected active pixels per line
HEIGHT, 480, expected active lines per frame

Ports:
clk  input  1  system clock (CLOCK_50 domain); all logic on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
vga_clk  input  1  sampled VGA_CLK; must be at most clk/2
vga_hs  input  1  horizontal sync, active-low
vga_vs  input  1  vertical sync, active-low
vga_blank_n  input  1  1 = active video
vga_r, vga_g, vga_b  input  8 each  pixel colour
pix_valid  output  1  one-cycle strobe, captured active pixel
pix_x  output  10  recovered x of captured pixel
pix_y  output  9  recovered y of captured pixel
pix_r, pix_g, pix_b  output  8 each  captured colour
frame_done  output  1  one-cycle pulse at end of each complete frame
frame_cksum  output  16  checksum of last completed frame
line_len  output  10  active length of last completed line
frame_lines  output  9  active line count of last completed frame
frame_err  output  1  last completed frame had a geometry error
err_count  output  8  saturating count of errored frames

Behaviour:
- Reset (reset==0 at a clk edge): every output 0, all counters 0, FSM to WAIT_VS. Applies mid-frame; no frame_done is emitted for an aborted frame.
- Strobe: vga_clk registered each clk; stb = vga_clk & ~vga_clk_q. All VGA inputs are sampled only on stb cycles; hs_q/vs_q/blank_q hold the previous sampled values.
- Sampling rule: inputs must be stable on the stb cycle.
- FSM states:
  - WAIT_VS: ignore everything until vs falling (vs_q=1, vs=0 at stb), then go to BLANK.
  - BLANK: blank_n=1 at stb goes to ACTIVE; that pixel is counted as x=0.
  - ACTIVE: each stb with blank_n=1 captures a pixel. blank_n=0 at stb ends the line and returns to BLANK.
- vs falling handling, in any state other than WAIT_VS:
  - Close the current frame.
  - Clear y, x and the running checksum.
  - Go to BLANK.
  - The first vs falling after reset opens a frame without emitting frame_done.
- Pixel capture:
  - Registered, latency 1 clk after stb: pix_valid=1 for exactly one clk, with pix_x = x, pix_y = y and pix_rgb = sampled rgb.
  - Then x <= x+1, saturating at 1023.
  - cksum <= {cksum[14:0],cksum[15]} + {r[7:3],g[7:2],b[7:3]}, mod 2^16.
- Line end (ACTIVE to BLANK):
  - line_len <= x; set line_bad if x != WIDTH; x <= 0.
  - y <= y+1, saturating at 511.
- Early line close: hs falling while in ACTIVE closes the line the same way and sets line_bad unconditionally.
- Frame close, registered 1 clk after the vs-falling stb:
  - frame_done=1 for one clk; frame_cksum <= cksum; frame_lines <= y.
  - frame_err <= line_bad | (y != HEIGHT); if set, err_count += 1, saturating at 255.
  - line_bad is then cleared.
  - If the state was ACTIVE at vs falling, the line is closed first (counted into y) and line_bad is set.
- Simultaneous events: vs falling together with blank_n=1 drops that pixel (no pix_valid), and the frame being closed is flagged error.
- Non-pixel outputs (line_len, frame_* and err_count) hold their values between updates.

Optional Feature:
VGA_MON_PROBE_EN:
- Defined: adds inputs probe_x[9:0], probe_y[8:0] and outputs probe_rgb[23:0], probe_hit.
- When a captured pixel matches (probe_x, probe_y), probe_rgb <= {r,g,b} with the same latency as pix_valid.
- probe_hit is set on a match and cleared at frame close; both reset to 0.
- Undefined: these ports and the logic do not exist; all other behaviour is identical.

Test Plan:
- Reset mid-frame: WIDTH=8, HEIGHT=4 bench; assert reset=0 for one clk during line 2 -> all outputs 0, and the next vs falling produces no frame_done.
- Clean frames: two frames of 4 lines x 8 pixels, rgb = x*16 -> pix_valid 32 times per frame with pix_x 0..7 and pix_y 0..3; frame_done once per frame; frame_lines=4, line_len=8, frame_err=0.
- Checksum: frame of all-white pixels (rgb = FF,FF,FF), 4x8 -> frame_cksum equals the rotate-add of 0xFFFF over 32 pixels, checked against a bench model; all-zero frame -> 0x0000.
- Short line: line 1 has 7 pixels -> line_len=7, frame_err=1, err_count=1.
- Extra line: frame of 5 lines -> frame_lines=5, frame_err=1.
- hs falling inside an active line closes that line and flags the frame.
- vs collision: vs falls on a stb with blank_n=1 -> no pix_valid for that stb, frame_err=1.
- err_count saturation: 256 bad frames -> err_count stays 255.

Source files
------------

// File: rtl/vga_monitor.sv
// VGA receive-side monitor. It recovers pixel coordinates, line and frame geometry, and a per-frame RGB565 checksum.
// Defining VGA_MON_PROBE_EN adds a single-pixel colour probe (probe_x/probe_y in, probe_rgb/probe_hit out).
module vga_monitor #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vga_clk,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic        vga_blank_n,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
`ifdef VGA_MON_PROBE_EN
  input  logic [9:0]  probe_x,
  input  logic [8:0]  probe_y,
  output logic [23:0] probe_rgb,
  output logic        probe_hit,
`endif
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [7:0]  pix_r,
  output logic [7:0]  pix_g,
  output logic [7:0]  pix_b,
  output logic        frame_done,
  output logic [15:0] frame_cksum,
  output logic [9:0]  line_len,
  output logic [8:0]  frame_lines,
  output logic        frame_err,
  output logic [7:0]  err_count
);

  // pix_valid and frame_done are single-cycle strobes with no back-pressure.
  // Their companion data is meaningful only while the strobe is high.
  typedef enum logic [1:0] {
    ST_WAIT_VS = 2'd0,
    ST_BLANK   = 2'd1,
    ST_ACTIVE  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        vga_clk_q, hs_q, vs_q;
  logic [9:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic [15:0] cksum_q, cksum_d;
  logic        line_bad_q, line_bad_d;
  logic        pix_valid_q, pix_valid_d;
  logic [9:0]  pix_x_q, pix_x_d;
  logic [8:0]  pix_y_q, pix_y_d;
  logic [7:0]  pix_r_q, pix_r_d, pix_g_q, pix_g_d, pix_b_q, pix_b_d;
  logic        frame_done_q, frame_done_d;
  logic [15:0] frame_cksum_q, frame_cksum_d;
  logic [9:0]  line_len_q, line_len_d;
  logic [8:0]  frame_lines_q, frame_lines_d;
  logic        frame_err_q, frame_err_d;
  logic [7:0]  err_count_q, err_count_d;
  logic [8:0]  lines_v;
  logic        bad_v;
`ifdef VGA_MON_PROBE_EN
  logic [23:0] probe_rgb_q, probe_rgb_d;
  logic        probe_hit_q, probe_hit_d;
`endif

  logic        stb, vs_fall, hs_fall;
  logic [9:0]  x_inc;
  logic [8:0]  y_inc;
  logic [7:0]  err_inc;
  logic [15:0] px565;

  assign stb     = vga_clk & ~vga_clk_q;
  assign vs_fall = stb & vs_q & ~vga_vs;
  assign hs_fall = stb & hs_q & ~vga_hs;
  assign x_inc   = (x_q == 10'h3FF) ? x_q : x_q + 10'd1;
  assign y_inc   = (y_q == 9'h1FF) ? y_q : y_q + 9'd1;
  assign err_inc = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;
  assign px565   = {vga_r[7:3], vga_g[7:2], vga_b[7:3]};

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    cksum_d       = cksum_q;
    line_bad_d    = line_bad_q;
    pix_valid_d   = 1'b0;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    pix_r_d       = pix_r_q;
    pix_g_d       = pix_g_q;
    pix_b_d       = pix_b_q;
    frame_done_d  = 1'b0;
    frame_cksum_d = frame_cksum_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    frame_err_d   = frame_err_q;
    err_count_d   = err_count_q;
    lines_v       = y_q;
    bad_v         = line_bad_q;
`ifdef VGA_MON_PROBE_EN
    probe_rgb_d   = probe_rgb_q;
    probe_hit_d   = probe_hit_q;
`endif
    if (stb) begin
      if (state_q == ST_WAIT_VS) begin
        // The first vsync after reset only opens a frame; there is nothing to close yet.
        if (vs_fall) state_d = ST_BLANK;
      end else if (vs_fall) begin
        // A pixel presented on the vsync stb is dropped and taints the closing frame.
        bad_v = line_bad_q | vga_blank_n;
        if (state_q == ST_ACTIVE) begin
          lines_v    = y_inc;
          bad_v      = 1'b1;
          line_len_d = x_q;
        end
        bad_v         = bad_v | (lines_v != 9'(HEIGHT));
        frame_done_d  = 1'b1;
        frame_cksum_d = cksum_q;
        frame_lines_d = lines_v;
        frame_err_d   = bad_v;
        if (bad_v) err_count_d = err_inc;
        x_d        = '0;
        y_d        = '0;
        cksum_d    = '0;
        line_bad_d = 1'b0;
        state_d    = ST_BLANK;
`ifdef VGA_MON_PROBE_EN
        probe_hit_d = 1'b0;
`endif
      end else if (state_q == ST_ACTIVE && (hs_fall || !vga_blank_n)) begin
        line_len_d = x_q;
        line_bad_d = line_bad_q | hs_fall | (x_q != 10'(WIDTH));
        x_d        = '0;
        y_d        = y_inc;
        state_d    = ST_BLANK;
      end else if (vga_blank_n) begin
        pix_valid_d = 1'b1;
        pix_x_d     = x_q;
        pix_y_d     = y_q;
        pix_r_d     = vga_r;
        pix_g_d     = vga_g;
        pix_b_d     = vga_b;
        x_d         = x_inc;
        cksum_d     = {cksum_q[14:0], cksum_q[15]} + px565;
        state_d     = ST_ACTIVE;
`ifdef VGA_MON_PROBE_EN
        if (x_q == probe_x && y_q == probe_y) begin
          probe_rgb_d = {vga_r, vga_g, vga_b};
          probe_hit_d = 1'b1;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_WAIT_VS;
      vga_clk_q     <= 1'b0;
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      cksum_q       <= '0;
      line_bad_q    <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_r_q       <= '0;
      pix_g_q       <= '0;
      pix_b_q       <= '0;
      frame_done_q  <= 1'b0;
      frame_cksum_q <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      frame_err_q   <= 1'b0;
      err_count_q   <= '0;
`ifdef VGA_MON_PROBE_EN
      probe_rgb_q   <= '0;
      probe_hit_q   <= 1'b0;
`endif
    end else begin
      vga_clk_q <= vga_clk;
      if (stb) begin
        hs_q <= vga_hs;
        vs_q <= vga_vs;
      end
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      cksum_q       <= cksum_d;
      line_bad_q    <= line_bad_d;
      pix_valid_q   <= pix_valid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_r_q       <= pix_r_d;
      pix_g_q       <= pix_g_d;
      pix_b_q       <= pix_b_d;
      frame_done_q  <= frame_done_d;
      frame_cksum_q <= frame_cksum_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      frame_err_q   <= frame_err_d;
      err_count_q   <= err_count_d;
`ifdef VGA_MON_PROBE_EN
      probe_rgb_q   <= probe_rgb_d;
      probe_hit_q   <= probe_hit_d;
`endif
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_r       = pix_r_q;
  assign pix_g       = pix_g_q;
  assign pix_b       = pix_b_q;
  assign frame_done  = frame_done_q;
  assign frame_cksum = frame_cksum_q;
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign frame_err   = frame_err_q;
  assign err_count   = err_count_q;
`ifdef VGA_MON_PROBE_EN
  assign probe_rgb   = probe_rgb_q;
  assign probe_hit   = probe_hit_q;
`endif

endmodule

// File: tb/tb_vga_monitor.sv
// Testbench for vga_monitor on a small 8x4 raster.
// A frame-level model predicts every pixel and every frame-close record.
module tb_vga_monitor;
  localparam int WIDTH  = 8;
  localparam int HEIGHT = 4;

  logic        clk = 1'b0, reset = 1'b0, vga_clk = 1'b0;
  logic        vga_hs = 1'b1, vga_vs = 1'b1, vga_blank_n = 1'b0;
  logic [7:0]  vga_r = '0, vga_g = '0, vga_b = '0;
  logic        pix_valid, frame_done, frame_err;
  logic [9:0]  pix_x, line_len;
  logic [8:0]  pix_y, frame_lines;
  logic [7:0]  pix_r, pix_g, pix_b, err_count;
  logic [15:0] frame_cksum;
`ifdef VGA_MON_PROBE_EN
  logic [9:0]  probe_x = 10'd3;
  logic [8:0]  probe_y = 9'd1;
  logic [23:0] probe_rgb;
  logic        probe_hit;
`endif

  vga_monitor #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
    .clk(clk), .reset(reset), .vga_clk(vga_clk), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
`ifdef VGA_MON_PROBE_EN
    .probe_x(probe_x), .probe_y(probe_y), .probe_rgb(probe_rgb), .probe_hit(probe_hit),
`endif
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_r(pix_r), .pix_g(pix_g),
    .pix_b(pix_b), .frame_done(frame_done), .frame_cksum(frame_cksum), .line_len(line_len),
    .frame_lines(frame_lines), .frame_err(frame_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int obs_pix_cnt = 0, obs_frame_cnt = 0;
  logic [42:0] exp_pix_q[$];
  logic [43:0] exp_frame_q[$];

  // Frame-level model state
  bit          m_frame_open = 1'b0, m_line_open = 1'b0, m_bad = 1'b0;
  int          m_y = 0, m_x = 0, m_line_len = 0, m_err_total = 0;
  logic [15:0] m_words[$];

  // Scoreboard: every pixel strobe and frame-close pulse is matched against the expected queues
  always @(negedge clk) begin
    logic [42:0] ep;
    logic [43:0] ef;
    if (pix_valid) begin
      obs_pix_cnt++;
      checks++;
      if (exp_pix_q.size() == 0) begin
        errors++;
        $display("FAIL pix_unexpected got y=%0d x=%0d rgb=%06h exp none", pix_y, pix_x, {pix_r, pix_g, pix_b});
      end else begin
        ep = exp_pix_q.pop_front();
        if ({pix_y, pix_x, pix_r, pix_g, pix_b} !== ep) begin
          errors++;
          $display("FAIL pix_data got y=%0d x=%0d rgb=%06h exp y=%0d x=%0d rgb=%06h",
                   pix_y, pix_x, {pix_r, pix_g, pix_b}, ep[42:34], ep[33:24], ep[23:0]);
        end
      end
    end
    if (frame_done) begin
      obs_frame_cnt++;
      checks++;
      if (exp_frame_q.size() == 0) begin
        errors++;
        $display("FAIL frame_unexpected got cksum=%04h lines=%0d exp none", frame_cksum, frame_lines);
      end else begin
        ef = exp_frame_q.pop_front();
        if ({frame_cksum, frame_lines, line_len, frame_err, err_count} !== ef) begin
          errors++;
          $display("FAIL frame_record got cksum=%04h lines=%0d len=%0d err=%0b cnt=%0d exp cksum=%04h lines=%0d len=%0d err=%0b cnt=%0d",
                   frame_cksum, frame_lines, line_len, frame_err, err_count,
                   ef[43:28], ef[27:19], ef[18:9], ef[8], ef[7:0]);
        end
      end
    end
  end

  function automatic logic [23:0] pat_rgb(input int pat, input int x);
    logic [7:0] v;
    v = 8'(x * 16);
    case (pat)
      1:       return {v, v, v};
      2:       return 24'hFFFFFF;
      3:       return 24'h000000;
      default: return 24'($urandom);
    endcase
  endfunction

  function automatic logic [15:0] rgb565(input logic [23:0] c);
    return {c[23:19], c[15:10], c[7:3]};
  endfunction

  // One VGA pixel period; called and returns at a falling clk edge.
  task automatic vga_stb(input logic hs, input logic vs, input logic blank, input logic [23:0] rgb);
    int lo, hi;
    lo = $urandom_range(1, 2);
    hi = $urandom_range(1, 2);
    vga_clk = 1'b0;
    vga_hs = hs; vga_vs = vs; vga_blank_n = blank;
    {vga_r, vga_g, vga_b} = rgb;
    repeat (lo) @(negedge clk);
    vga_clk = 1'b1;
    repeat (hi) @(negedge clk);
  endtask

  // mode 0: ends on blank, 1: ends on blank with hs falling, 2: left open
  task automatic drive_line(input int n, input int mode, input int pat);
    logic [23:0] rgb;
    vga_stb(1'b0, 1'b1, 1'b0, 24'($urandom));
    vga_stb(1'b1, 1'b1, 1'b0, 24'($urandom));
    for (int i = 0; i < n; i++) begin
      rgb = pat_rgb(pat, i);
      if (m_frame_open) begin
        exp_pix_q.push_back({9'(m_y), 10'(i), rgb});
        m_words.push_back(rgb565(rgb));
      end
      vga_stb(1'b1, 1'b1, 1'b1, rgb);
    end
    if (mode == 2) begin
      m_line_open = m_frame_open;
      m_x = n;
    end else begin
      if (m_frame_open) begin
        m_line_len = n;
        m_y++;
        if (n != WIDTH || mode == 1) m_bad = 1'b1;
      end
      vga_stb(mode == 1 ? 1'b0 : 1'b1, 1'b1, 1'b0, 24'($urandom));
      vga_stb(1'b1, 1'b1, 1'b0, 24'($urandom));
    end
  endtask

  task automatic drive_vs_fall(input logic collide);
    logic [15:0] c;
    bit bad;
    if (m_frame_open) begin
      if (m_line_open) begin
        m_line_len = m_x;
        m_y++;
        m_bad = 1'b1;
      end
      bad = m_bad | collide | (m_y != HEIGHT);
      c = '0;
      foreach (m_words[i]) c = {c[14:0], c[15]} + m_words[i];
      if (bad) m_err_total++;
      exp_frame_q.push_back({c, 9'(m_y), 10'(m_line_len), bad,
                             (m_err_total > 255) ? 8'd255 : 8'(m_err_total)});
    end
    m_frame_open = 1'b1; m_line_open = 1'b0; m_y = 0; m_bad = 1'b0;
    m_words.delete();
    vga_stb(1'b1, 1'b0, collide, 24'($urandom));
    vga_stb(1'b1, 1'b0, 1'b0, 24'($urandom));
    vga_stb(1'b1, 1'b1, 1'b0, 24'($urandom));
    vga_stb(1'b1, 1'b1, 1'b0, 24'($urandom));
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({pix_valid, pix_x, pix_y, pix_r, pix_g, pix_b, frame_done, frame_cksum} !== '0) begin
      errors++;
      $display("FAIL reset_pix_outputs got=%0h exp=0", {pix_valid, pix_x, pix_y, pix_r, pix_g, pix_b, frame_done, frame_cksum});
    end
    checks++;
    if ({line_len, frame_lines, frame_err, err_count} !== '0) begin
      errors++;
      $display("FAIL reset_geom_outputs got=%0h exp=0", {line_len, frame_lines, frame_err, err_count});
    end
    reset = 1'b1;
    vga_stb(1'b1, 1'b1, 1'b0, 24'h0);
    drive_vs_fall(1'b0);
  endtask

  task automatic test_clean_frames;
    int p0, f0;
    p0 = obs_pix_cnt; f0 = obs_frame_cnt;
    for (int f = 0; f < 2; f++) begin
      for (int l = 0; l < HEIGHT; l++) drive_line(WIDTH, 0, 1);
      drive_vs_fall(1'b0);
    end
    checks++;
    if (obs_pix_cnt - p0 !== 64) begin errors++; $display("FAIL clean_pix_count got=%0d exp=64", obs_pix_cnt - p0); end
    checks++;
    if (obs_frame_cnt - f0 !== 2) begin errors++; $display("FAIL clean_frame_count got=%0d exp=2", obs_frame_cnt - f0); end
    checks++;
    if ({frame_lines, line_len, frame_err, err_count} !== {9'd4, 10'd8, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL clean_geometry got lines=%0d len=%0d err=%0b cnt=%0d exp 4 8 0 0", frame_lines, line_len, frame_err, err_count);
    end
  endtask

  task automatic test_checksum;
    logic [15:0] c;
    c = '0;
    repeat (32) c = {c[14:0], c[15]} + 16'hFFFF;
    for (int l = 0; l < HEIGHT; l++) drive_line(WIDTH, 0, 2);
    drive_vs_fall(1'b0);
    checks++;
    if (frame_cksum !== c) begin errors++; $display("FAIL cksum_white got=%04h exp=%04h", frame_cksum, c); end
    for (int l = 0; l < HEIGHT; l++) drive_line(WIDTH, 0, 3);
    drive_vs_fall(1'b0);
    checks++;
    if (frame_cksum !== 16'h0000) begin errors++; $display("FAIL cksum_zero got=%04h exp=0000", frame_cksum); end
  endtask

  task automatic test_short_line;
    drive_line(WIDTH, 0, 0);
    drive_line(WIDTH - 1, 0, 0);
    checks++;
    if (line_len !== 10'd7) begin errors++; $display("FAIL short_line_len got=%0d exp=7", line_len); end
    drive_line(WIDTH, 0, 0);
    drive_line(WIDTH, 0, 0);
    drive_vs_fall(1'b0);
    checks++;
    if ({frame_err, err_count} !== {1'b1, 8'd1}) begin
      errors++; $display("FAIL short_frame_err got err=%0b cnt=%0d exp 1 1", frame_err, err_count);
    end
  endtask

  task automatic test_extra_line;
    for (int l = 0; l < HEIGHT + 1; l++) drive_line(WIDTH, 0, 0);
    drive_vs_fall(1'b0);
    checks++;
    if ({frame_lines, frame_err, err_count} !== {9'd5, 1'b1, 8'd2}) begin
      errors++; $display("FAIL extra_line got lines=%0d err=%0b cnt=%0d exp 5 1 2", frame_lines, frame_err, err_count);
    end
  endtask

  task automatic test_hs_fall;
    drive_line(WIDTH, 0, 0);
    drive_line(WIDTH, 1, 0);
    checks++;
    if (line_len !== 10'd8) begin errors++; $display("FAIL hs_line_len got=%0d exp=8", line_len); end
    drive_line(WIDTH, 0, 0);
    drive_line(WIDTH, 0, 0);
    drive_vs_fall(1'b0);
    checks++;
    if ({frame_lines, frame_err, err_count} !== {9'd4, 1'b1, 8'd3}) begin
      errors++; $display("FAIL hs_frame got lines=%0d err=%0b cnt=%0d exp 4 1 3", frame_lines, frame_err, err_count);
    end
  endtask

  task automatic test_vs_collision;
    int p0;
    p0 = obs_pix_cnt;
    for (int l = 0; l < HEIGHT; l++) drive_line(WIDTH, 0, 0);
    drive_vs_fall(1'b1);
    checks++;
    if ({frame_lines, frame_err, err_count} !== {9'd4, 1'b1, 8'd4}) begin
      errors++; $display("FAIL collide_blank got lines=%0d err=%0b cnt=%0d exp 4 1 4", frame_lines, frame_err, err_count);
    end
    for (int l = 0; l < HEIGHT - 1; l++) drive_line(WIDTH, 0, 0);
    drive_line(5, 2, 0);
    drive_vs_fall(1'b1);
    checks++;
    if ({frame_lines, line_len, frame_err, err_count} !== {9'd4, 10'd5, 1'b1, 8'd5}) begin
      errors++;
      $display("FAIL collide_active got lines=%0d len=%0d err=%0b cnt=%0d exp 4 5 1 5", frame_lines, line_len, frame_err, err_count);
    end
    checks++;
    if (obs_pix_cnt - p0 !== 61) begin errors++; $display("FAIL collide_pix_count got=%0d exp=61", obs_pix_cnt - p0); end
  endtask

  task automatic test_random_frames;
    int nl, len, last;
    bit bad;
    for (int f = 0; f < 3; f++) begin
      nl = $urandom_range(3, 5);
      bad = (nl != HEIGHT);
      last = 0;
      for (int l = 0; l < nl; l++) begin
        len = $urandom_range(7, 9);
        if (len != WIDTH) bad = 1'b1;
        last = len;
        drive_line(len, 0, 0);
      end
      drive_vs_fall(1'b0);
      checks++;
      if ({frame_lines, line_len, frame_err} !== {9'(nl), 10'(last), bad}) begin
        errors++;
        $display("FAIL random_frame got lines=%0d len=%0d err=%0b exp %0d %0d %0b", frame_lines, line_len, frame_err, nl, last, bad);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    int p0, f0;
    drive_line(WIDTH, 0, 0);
    drive_line(WIDTH, 0, 0);
    drive_line(5, 2, 0);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({pix_valid, pix_x, pix_y, pix_r, pix_g, pix_b, frame_done, frame_cksum} !== '0) begin
      errors++;
      $display("FAIL midreset_pix_outputs got=%0h exp=0", {pix_valid, pix_x, pix_y, pix_r, pix_g, pix_b, frame_done, frame_cksum});
    end
    checks++;
    if ({line_len, frame_lines, frame_err, err_count} !== '0) begin
      errors++;
      $display("FAIL midreset_geom_outputs got=%0h exp=0", {line_len, frame_lines, frame_err, err_count});
    end
    reset = 1'b1;
    m_frame_open = 1'b0; m_line_open = 1'b0; m_y = 0; m_bad = 1'b0;
    m_line_len = 0; m_err_total = 0;
    m_words.delete();
    p0 = obs_pix_cnt; f0 = obs_frame_cnt;
    drive_line(WIDTH, 0, 1);
    drive_vs_fall(1'b0);
    checks++;
    if (obs_frame_cnt - f0 !== 0) begin errors++; $display("FAIL midreset_frame_done got=%0d exp=0", obs_frame_cnt - f0); end
    checks++;
    if (obs_pix_cnt - p0 !== 0) begin errors++; $display("FAIL midreset_pix_count got=%0d exp=0", obs_pix_cnt - p0); end
  endtask

  task automatic test_err_saturation;
    for (int f = 0; f < 257; f++) begin
      drive_line(3, 0, 0);
      drive_vs_fall(1'b0);
    end
    checks++;
    if ({frame_err, err_count} !== {1'b1, 8'd255}) begin
      errors++; $display("FAIL err_saturation got err=%0b cnt=%0d exp 1 255", frame_err, err_count);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_clean_frames;
    test_checksum;
    test_short_line;
    test_extra_line;
    test_hs_fall;
    test_vs_collision;
    test_random_frames;
    test_reset_mid_frame;
    test_err_saturation;
    repeat (4) @(negedge clk);
    checks++;
    if (exp_pix_q.size() !== 0) begin errors++; $display("FAIL pix_missing got=%0d exp=0", exp_pix_q.size()); end
    checks++;
    if (exp_frame_q.size() !== 0) begin errors++; $display("FAIL frame_missing got=%0d exp=0", exp_frame_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
